key_event_detector: RTL
=======================

// Module: key_event_detector
// PURPOSE
//   Consumes the debounced, active-low key level from the KeyScan debouncer and turns it into
//   single-cycle event pulses (press, release, click, long-press, auto-repeat) plus a held level.
//   Sits between the debouncer and the application FSMs/display logic, all in the system clock domain.
// PARAMETERS
//   F_CLK      50000000  system clock frequency in Hz; TICK_DIV = F_CLK/1000 clocks per 1 ms tick
//   LONG_MS    1000      hold time in ms before key_long fires (>=1)
//   REPEAT_MS  200       auto-repeat period in ms once long-press is reached (>=1)
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  asynchronous, active-high reset
//   key_state   in   1  debounced key level, 1 = released, 0 = pressed
//   key_press   out  1  1-cycle pulse on press edge
//   key_release out  1  1-cycle pulse on release edge
//   key_click   out  1  1-cycle pulse on release before long-press threshold
//   key_long    out  1  1-cycle pulse when hold reaches LONG_MS
//   key_repeat  out  1  1-cycle pulse every REPEAT_MS while in LONG (0 if KEY_REPEAT_EN undefined)
//   key_held    out  1  level, 1 while state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, key_q (registered key_state)=1, ms counter=0, tick prescaler=0, all outputs 0.
//     A key held through reset release is therefore reported as a fresh press.
//   - Edges: press = key_q & ~key_state, release = ~key_q & key_state; all outputs registered,
//     pulse appears the cycle after the edge is sampled, exactly 1 cycle wide.
//   - Prescaler counts 0..TICK_DIV-1, tick on terminal count; cleared on press edge so timing is
//     aligned: key_long asserts exactly LONG_MS*TICK_DIV cycles after key_press.
//   - FSM IDLE -> HELD on press edge (ms_cnt cleared, key_press, key_held=1).
//     HELD: ms_cnt++ per tick; at LONG_MS ticks -> LONG, pulse key_long, ms_cnt cleared.
//     HELD, release edge -> IDLE, pulse key_release and key_click together.
//     LONG, release edge -> IDLE, pulse key_release only (no click).
//     LONG: with repeat, ms_cnt++ per tick; at REPEAT_MS ticks pulse key_repeat, ms_cnt cleared.
//   - Simultaneous release and long/repeat threshold in same cycle: release wins; no key_long /
//     key_repeat, click issued if state was HELD.
//   - ms_cnt width $clog2(max(LONG_MS,REPEAT_MS)+1); saturates, never wraps.
//   - Press edge while not IDLE cannot occur (needs a prior release); FSM ignores it.
//   - Reset asserted mid-hold: returns to IDLE immediately, no release/click pulse generated.
// CONFIGURATION
//   KEY_REPEAT_EN defined: auto-repeat active as above.
//   KEY_REPEAT_EN undefined: key_repeat tied 0, LONG is terminal until release; ms_cnt frozen
//     in LONG; port list unchanged.
// STRUCTURE
//   key_event_pkg: enum key_state_e {IDLE, HELD, LONG}, localparam MS_PER_S=1000, a max() function
//     for counter sizing.
//   Sub-module ms_tick_gen (params F_CLK; ports clk, rst, clr, tick) holds the prescaler.
// TESTING  (F_CLK=10000 -> TICK_DIV=10, LONG_MS=5, REPEAT_MS=2)
//   - Reset with key_state=1, release rst -> all outputs 0, key_held 0 for 20 cycles.
//   - key_state 1->0 at cycle 0, back to 1 at cycle 20 -> key_press @1, key_held 1..20,
//     key_release+key_click @21, no key_long.
//   - Hold from cycle 0 for 120 cycles -> key_press @1, key_long @51, key_repeat @71,91,111
//     (KEY_REPEAT_EN), release pulse only at 121, no click.
//   - Same as above without KEY_REPEAT_EN -> key_repeat never asserts, key_long @51 once.
//   - Release timed to coincide with the long-threshold tick -> key_click+key_release, no key_long.
//   - Assert rst at cycle 30 of a hold, release at 35 with key_state=0 -> no release/click;
//     key_press one cycle after rst deasserts, timing restarts from there.

Source files
------------

// File: rtl/key_event_detector_pkg.sv
// Shared types and sizing helpers for the key event detector.
// Its users enable auto-repeat with the KEY_REPEAT_EN macro.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } key_state_e;

  localparam int unsigned MS_PER_S = 1000;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_detector_if.sv
// Key level in, event pulses and held level out.
// The detector uses the slave modport and the consumer uses the master modport.
interface key_event_detector_if;
  logic key_state;
  logic key_press;
  logic key_release;
  logic key_click;
  logic key_long;
  logic key_repeat;
  logic key_held;

  modport master (
    output key_state,
    input  key_press, key_release, key_click, key_long, key_repeat, key_held
  );

  modport slave (
    input  key_state,
    output key_press, key_release, key_click, key_long, key_repeat, key_held
  );
endinterface

// File: rtl/key_event_detector_ms_tick_gen.sv
// 1 ms tick prescaler that counts 0..TICK_DIV-1 and ticks on the terminal count.
// The clr input realigns it to a key press.
module ms_tick_gen
  import key_event_pkg::*;
#(
  parameter int unsigned F_CLK = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TICK_DIV = F_CLK / MS_PER_S;
  localparam int unsigned PW       = max($clog2(TICK_DIV), 1);
  localparam logic [PW-1:0] TC     = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == TC)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TC);

endmodule

// File: rtl/key_event_detector.sv
// Turns a debounced, active-low key level into press/release/click/long/repeat pulses and a held level.
// Auto-repeat is built only when KEY_REPEAT_EN is defined. Otherwise key_repeat is tied low.
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int unsigned F_CLK     = 50000000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input logic                 clk,
  input logic                 rst,
  key_event_detector_if.slave bus
);

  localparam int unsigned CNT_W         = $clog2(max(LONG_MS, REPEAT_MS) + 1);
  localparam logic [CNT_W-1:0] LONG_TC  = CNT_W'(LONG_MS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_MS - 1);
`endif

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] ms_q, ms_d, ms_inc;
  logic             key_q;
  logic             press_edge, release_edge, tick;
  logic             press_q, press_d, release_q, release_d, click_q, click_d;
  logic             long_q, long_d, held_q, held_d;
`ifdef KEY_REPEAT_EN
  logic             repeat_q, repeat_d;
`endif

  assign press_edge   = key_q & ~bus.key_state;
  assign release_edge = ~key_q & bus.key_state;
  assign ms_inc       = (ms_q == '1) ? ms_q : ms_q + 1'b1;

  ms_tick_gen #(.F_CLK(F_CLK)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (press_edge),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ms_q    <= '0;
      key_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      key_q   <= bus.key_state;
    end
  end

  // A release edge takes priority over a threshold tick in the same cycle.
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    unique case (state_q)
      IDLE: begin
        if (press_edge) begin
          state_d = HELD;
          ms_d    = '0;
        end
      end
      HELD: begin
        if (release_edge) begin
          state_d = IDLE;
        end else if (tick) begin
          if (ms_q == LONG_TC) begin
            state_d = LONG;
            ms_d    = '0;
          end else begin
            ms_d = ms_inc;
          end
        end
      end
      LONG: begin
        if (release_edge) begin
          state_d = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (tick) begin
          ms_d = (ms_q == REPEAT_TC) ? '0 : ms_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_d   = (state_q == IDLE) && press_edge;
    release_d = (state_q != IDLE) && release_edge;
    click_d   = (state_q == HELD) && release_edge;
    long_d    = (state_q == HELD) && !release_edge && tick && (ms_q == LONG_TC);
    held_d    = (state_d != IDLE);
`ifdef KEY_REPEAT_EN
    repeat_d  = (state_q == LONG) && !release_edge && tick && (ms_q == REPEAT_TC);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      held_q    <= held_d;
`ifdef KEY_REPEAT_EN
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.key_click   = click_q;
  assign bus.key_long    = long_q;
  assign bus.key_held    = held_q;
`ifdef KEY_REPEAT_EN
  assign bus.key_repeat  = repeat_q;
`else
  assign bus.key_repeat  = 1'b0;
`endif

endmodule
